// File: rtl/cross_bar_arbiter.sv
// Per-slave round-robin arbiter producing the 4x4 cross-bar grant matrix; each grant is held until the session ends or the watchdog fires.
// Latency: a request visible in cycle t is granted in cycle t+1; a release takes effect one edge after done or expiry.
// Backpressure: a requesting master simply waits while its target slave is busy or another master wins the round-robin scan.
module cross_bar_arbiter #(
  parameter int N_MASTERS = 4,
  parameter int N_SLAVES  = 4,
  parameter int TIMEOUT   = 256
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [N_MASTERS-1:0]                          master_req,
  input  logic [N_MASTERS-1:0][$clog2(N_SLAVES)-1:0]    master_sel,
  input  logic [N_SLAVES-1:0]                           session_is_finished,
  output logic [N_SLAVES-1:0][N_MASTERS-1:0]            granted_matrix,
  output logic [N_MASTERS-1:0]                          master_granted,
  output logic [N_SLAVES-1:0]                           timeout_err
);

  localparam int MW = $clog2(N_MASTERS);
  localparam int SW = $clog2(N_SLAVES);
  // Keep at least one counter bit so TIMEOUT=0 still elaborates; the counter then never moves.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                             state_q  [N_SLAVES];
  state_t                             state_d  [N_SLAVES];
  logic   [MW-1:0]                    ptr_q    [N_SLAVES];
  logic   [MW-1:0]                    ptr_d    [N_SLAVES];
  logic   [CW-1:0]                    cnt_q    [N_SLAVES];
  logic   [CW-1:0]                    cnt_d    [N_SLAVES];
  logic   [N_MASTERS-1:0]             cand     [N_SLAVES];
  logic                               pick_vld [N_SLAVES];
  logic   [MW-1:0]                    pick_idx [N_SLAVES];
  logic                               done     [N_SLAVES];
  logic                               expire   [N_SLAVES];
  logic   [N_SLAVES-1:0][N_MASTERS-1:0] row_d;
  logic   [N_SLAVES-1:0]              terr_d;
  logic   [N_MASTERS-1:0]             mg_d;

  // Round-robin pick per slave: first candidate at or after ptr, wrapping mod N_MASTERS (power of two).
  always_comb begin
    for (int s = 0; s < N_SLAVES; s++) begin
      cand[s]     = '0;
      pick_vld[s] = 1'b0;
      pick_idx[s] = '0;
      for (int m = 0; m < N_MASTERS; m++) begin
        cand[s][m] = master_req[m] && (master_sel[m] == SW'(s)) && !master_granted[m];
      end
      // Scan from farthest to nearest so the nearest candidate overwrites the rest.
      for (int off = N_MASTERS - 1; off >= 0; off--) begin
        if (cand[s][ptr_q[s] + MW'(off)]) begin
          pick_vld[s] = 1'b1;
          pick_idx[s] = ptr_q[s] + MW'(off);
        end
      end
    end
  end

  // Next-state logic: IDLE leaves on a pick, BUSY leaves on done (priority) or watchdog expiry.
  always_comb begin
    for (int s = 0; s < N_SLAVES; s++) begin
      done[s]    = (state_q[s] == BUSY) && session_is_finished[s];
      expire[s]  = (TIMEOUT != 0) && (state_q[s] == BUSY) && !session_is_finished[s] &&
                   (cnt_q[s] == CNT_LAST);
      state_d[s] = state_q[s];
      case (state_q[s])
        IDLE:    if (pick_vld[s]) state_d[s] = BUSY;
        BUSY:    if (done[s] || expire[s]) state_d[s] = IDLE;
        default: state_d[s] = IDLE;
      endcase
    end
  end

  // Output/datapath next values: grant row, pointer, hold counter and watchdog pulse.
  always_comb begin
    mg_d = '0;
    for (int s = 0; s < N_SLAVES; s++) begin
      row_d[s]  = granted_matrix[s];
      ptr_d[s]  = ptr_q[s];
      cnt_d[s]  = cnt_q[s];
      terr_d[s] = 1'b0;
      if (state_q[s] == IDLE) begin
        row_d[s] = '0;
        if (pick_vld[s]) begin
          row_d[s][pick_idx[s]] = 1'b1;
          ptr_d[s] = pick_idx[s] + MW'(1);
          cnt_d[s] = '0;
        end
      end else if (done[s] || expire[s]) begin
        row_d[s]  = '0;
        terr_d[s] = expire[s];
      end else if (TIMEOUT != 0) begin
        cnt_d[s] = cnt_q[s] + CW'(1);
      end
      mg_d = mg_d | row_d[s];
    end
  end

  // State register: matrix and per-master summary update on the same edge so they always agree.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < N_SLAVES; s++) begin
        state_q[s] <= IDLE;
        ptr_q[s]   <= '0;
        cnt_q[s]   <= '0;
      end
      granted_matrix <= '0;
      master_granted <= '0;
      timeout_err    <= '0;
    end else begin
      for (int s = 0; s < N_SLAVES; s++) begin
        state_q[s] <= state_d[s];
        ptr_q[s]   <= ptr_d[s];
        cnt_q[s]   <= cnt_d[s];
      end
      granted_matrix <= row_d;
      master_granted <= mg_d;
      timeout_err    <= terr_d;
    end
  end

endmodule
